// File: rtl/status_flag_ctrl_pkg.sv
// Shared definitions for the NZCV status/condition scheduling block:
// condition-code encodings, flag bit positions and the default writer depth.
package status_flag_ctrl_pkg;

  localparam int DEFAULT_PIPE_DEPTH = 2;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // AL and NV never read the flags, so they never wait on a flag writer.
  function automatic logic cond_is_always(input logic [3:0] cond);
    return (cond == COND_AL) || (cond == COND_NV);
  endfunction

endpackage

// File: rtl/status_flag_ctrl_cond_eval.sv
// Combinational condition-code evaluator: decides whether a 4-bit condition
// holds for a given {N,Z,C,V} flag set.
module status_flag_ctrl_cond_eval
  import status_flag_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b1;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      default: pass = 1'b1;
    endcase
  end

endmodule

// File: rtl/status_flag_ctrl.sv
// Architectural NZCV register plus ID-stage scheduling of conditional
// instructions against in-flight flag writers, with EXE flag bypass.
module status_flag_ctrl
  import status_flag_ctrl_pkg::*;
#(
  parameter int PIPE_DEPTH = DEFAULT_PIPE_DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       idValid,
  input  logic [3:0] idCond,
  input  logic       idSetFlags,
  input  logic       flush,
  input  logic       exeFlagsValid,
  input  logic [3:0] exeNzcv,
  output logic       stall,
  output logic       issue,
  output logic       condPass,
  output logic [3:0] nzcv,
  output logic       err
);

  localparam int              PW       = $clog2(PIPE_DEPTH + 1);
  localparam logic [PW-1:0]   PEND_MAX = PW'(PIPE_DEPTH);
  localparam logic [PW-1:0]   PEND_ONE = PW'(1);

  logic [PW-1:0] pending_reg, pending_next;
  logic [3:0]    nzcv_reg;
  logic          err_reg, err_next;
  logic [3:0]    eff_flags;
  logic          resolved;
  logic          cond_hazard;
  logic          writer_full;
  logic          inc;

  // Flags just produced in EXE take precedence so a dependent branch needs no bubble.
  assign eff_flags = exeFlagsValid ? exeNzcv : nzcv_reg;

  assign resolved    = (pending_reg == '0) ||
                       ((pending_reg == PEND_ONE) && exeFlagsValid);
  assign cond_hazard = ~cond_is_always(idCond) & ~resolved;
  assign writer_full = idSetFlags & (pending_reg == PEND_MAX) & ~exeFlagsValid;

  assign stall = idValid & ~flush & (cond_hazard | writer_full);
  assign issue = idValid & ~flush & ~stall;
  assign inc   = issue & idSetFlags;

  status_flag_ctrl_cond_eval u_cond_eval (
    .cond  (idCond),
    .flags (eff_flags),
    .pass  (condPass)
  );

  // A writeback with nothing in flight is a protocol slip: flag it, keep count at 0.
  always_comb begin
    pending_next = pending_reg;
    if (flush) begin
      pending_next = '0;
    end else if (inc && !exeFlagsValid) begin
      pending_next = pending_reg + PEND_ONE;
    end else if (!inc && exeFlagsValid && (pending_reg != '0)) begin
      pending_next = pending_reg - PEND_ONE;
    end
  end

  always_comb begin
    err_next = err_reg | (exeFlagsValid & ~flush & (pending_reg == '0));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_reg <= '0;
      nzcv_reg    <= 4'b0000;
      err_reg     <= 1'b0;
    end else begin
      pending_reg <= pending_next;
      err_reg     <= err_next;
      if (exeFlagsValid) begin
        nzcv_reg <= exeNzcv;
      end
    end
  end

  assign nzcv = nzcv_reg;
  assign err  = err_reg;

endmodule

// File: tb/tb_status_flag_ctrl.sv
// Self-checking bench for status_flag_ctrl: per-scenario tasks push expected
// output vectors to a scoreboard and compare them once the outputs settle.
module tb_status_flag_ctrl;

  logic       clk;
  logic       rst;
  logic       idValid;
  logic [3:0] idCond;
  logic       idSetFlags;
  logic       flush;
  logic       exeFlagsValid;
  logic [3:0] exeNzcv;
  logic       stall;
  logic       issue;
  logic       condPass;
  logic [3:0] nzcv;
  logic       err;

  int checks;
  int failures;

  // Expected vector layout: {stall, issue, condPass, nzcv[3:0], err}
  typedef struct {
    logic [7:0] exp;
    logic [7:0] care;
  } exp_t;

  exp_t sb[$];

  localparam logic [7:0] CARE_ALL  = 8'hFF;
  localparam logic [7:0] CARE_NOCP = 8'hDF;

  status_flag_ctrl #(.PIPE_DEPTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .idValid       (idValid),
    .idCond        (idCond),
    .idSetFlags    (idSetFlags),
    .flush         (flush),
    .exeFlagsValid (exeFlagsValid),
    .exeNzcv       (exeNzcv),
    .stall         (stall),
    .issue         (issue),
    .condPass      (condPass),
    .nzcv          (nzcv),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus layout: {idValid, idCond[3:0], idSetFlags, flush, exeFlagsValid, exeNzcv[3:0]}
  task automatic drive(input logic [11:0] s);
    @(negedge clk);
    {idValid, idCond, idSetFlags, flush, exeFlagsValid, exeNzcv} = s;
    #1;
  endtask

  function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  task automatic test_reset();
    logic [11:0] st [3];
    exp_t        ex [3];
    exp_t        e;
    logic [7:0]  got;
    st = '{ {1'b1,4'h0,1'b0,1'b0,1'b0,4'h0},
            {1'b1,4'h0,1'b0,1'b0,1'b0,4'h0},
            {1'b1,4'h1,1'b0,1'b0,1'b0,4'h0} };
    ex = '{ '{ {1'b0,1'b1,1'b0,4'h0,1'b0}, CARE_ALL },
            '{ {1'b0,1'b1,1'b0,4'h0,1'b0}, CARE_ALL },
            '{ {1'b0,1'b1,1'b1,4'h0,1'b0}, CARE_ALL } };
    for (int i = 0; i < 3; i++) begin
      if (i == 1) rst = 1'b1;
      sb.push_back(ex[i]);
      drive(st[i]);
      e   = sb.pop_front();
      got = {stall, issue, condPass, nzcv, err};
      checks++;
      if ((got & e.care) !== (e.exp & e.care)) begin
        failures++;
        $display("FAIL reset[%0d] got=%b expected=%b care=%b", i, got, e.exp, e.care);
      end else
        $display("reset[%0d] ok out=%b", i, got);
    end
  endtask

  task automatic test_bypass();
    logic [11:0] st [4];
    exp_t        ex [4];
    exp_t        e;
    logic [7:0]  got;
    st = '{ {1'b1,4'hE,1'b1,1'b0,1'b0,4'h0},
            {1'b1,4'h0,1'b0,1'b0,1'b0,4'h0},
            {1'b1,4'h0,1'b0,1'b0,1'b1,4'h4},
            {1'b0,4'h0,1'b0,1'b0,1'b0,4'h0} };
    ex = '{ '{ {1'b0,1'b1,1'b1,4'h0,1'b0}, CARE_ALL },
            '{ {1'b1,1'b0,1'b0,4'h0,1'b0}, CARE_NOCP },
            '{ {1'b0,1'b1,1'b1,4'h0,1'b0}, CARE_ALL },
            '{ {1'b0,1'b0,1'b0,4'h4,1'b0}, CARE_NOCP } };
    for (int i = 0; i < 4; i++) begin
      sb.push_back(ex[i]);
      drive(st[i]);
      e   = sb.pop_front();
      got = {stall, issue, condPass, nzcv, err};
      checks++;
      if ((got & e.care) !== (e.exp & e.care)) begin
        failures++;
        $display("FAIL bypass[%0d] got=%b expected=%b care=%b", i, got, e.exp, e.care);
      end else
        $display("bypass[%0d] ok out=%b", i, got);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] st [5];
    exp_t        ex [5];
    exp_t        e;
    logic [7:0]  got;
    st = '{ {1'b1,4'hE,1'b1,1'b0,1'b0,4'h0},
            {1'b1,4'hE,1'b1,1'b0,1'b0,4'h0},
            {1'b1,4'hE,1'b1,1'b0,1'b0,4'h0},
            {1'b1,4'hE,1'b1,1'b0,1'b1,4'h2},
            {1'b1,4'hE,1'b1,1'b0,1'b0,4'h0} };
    ex = '{ '{ {1'b0,1'b1,1'b1,4'h4,1'b0}, CARE_ALL },
            '{ {1'b0,1'b1,1'b1,4'h4,1'b0}, CARE_ALL },
            '{ {1'b1,1'b0,1'b0,4'h4,1'b0}, CARE_NOCP },
            '{ {1'b0,1'b1,1'b1,4'h4,1'b0}, CARE_ALL },
            '{ {1'b1,1'b0,1'b0,4'h2,1'b0}, CARE_NOCP } };
    for (int i = 0; i < 5; i++) begin
      sb.push_back(ex[i]);
      drive(st[i]);
      e   = sb.pop_front();
      got = {stall, issue, condPass, nzcv, err};
      checks++;
      if ((got & e.care) !== (e.exp & e.care)) begin
        failures++;
        $display("FAIL b2b[%0d] got=%b expected=%b care=%b", i, got, e.exp, e.care);
      end else
        $display("b2b[%0d] ok out=%b", i, got);
    end
  endtask

  task automatic test_flush();
    logic [11:0] st [7];
    exp_t        ex [7];
    exp_t        e;
    logic [7:0]  got;
    st = '{ {1'b1,4'h0,1'b0,1'b1,1'b1,4'h9},
            {1'b1,4'hB,1'b0,1'b0,1'b0,4'h0},
            {1'b1,4'hA,1'b0,1'b0,1'b0,4'h0},
            {1'b1,4'hA,1'b1,1'b0,1'b0,4'h0},
            {1'b1,4'h1,1'b0,1'b0,1'b0,4'h0},
            {1'b0,4'h0,1'b0,1'b0,1'b1,4'h3},
            {1'b1,4'h3,1'b0,1'b0,1'b0,4'h0} };
    ex = '{ '{ {1'b0,1'b0,1'b0,4'h2,1'b0}, CARE_NOCP },
            '{ {1'b0,1'b1,1'b0,4'h9,1'b0}, CARE_ALL },
            '{ {1'b0,1'b1,1'b1,4'h9,1'b0}, CARE_ALL },
            '{ {1'b0,1'b1,1'b1,4'h9,1'b0}, CARE_ALL },
            '{ {1'b1,1'b0,1'b0,4'h9,1'b0}, CARE_NOCP },
            '{ {1'b0,1'b0,1'b0,4'h9,1'b0}, CARE_NOCP },
            '{ {1'b0,1'b1,1'b0,4'h3,1'b0}, CARE_ALL } };
    for (int i = 0; i < 7; i++) begin
      sb.push_back(ex[i]);
      drive(st[i]);
      e   = sb.pop_front();
      got = {stall, issue, condPass, nzcv, err};
      checks++;
      if ((got & e.care) !== (e.exp & e.care)) begin
        failures++;
        $display("FAIL flush[%0d] got=%b expected=%b care=%b", i, got, e.exp, e.care);
      end else
        $display("flush[%0d] ok out=%b", i, got);
    end
  endtask

  task automatic test_err();
    logic [11:0] st [5];
    exp_t        ex [5];
    exp_t        e;
    logic [7:0]  got;
    st = '{ {1'b0,4'h0,1'b0,1'b0,1'b1,4'h7},
            {1'b0,4'h0,1'b0,1'b0,1'b0,4'h0},
            {1'b1,4'hE,1'b0,1'b0,1'b0,4'h0},
            {1'b1,4'hE,1'b1,1'b0,1'b1,4'h5},
            {1'b1,4'h0,1'b0,1'b0,1'b0,4'h0} };
    ex = '{ '{ {1'b0,1'b0,1'b0,4'h3,1'b0}, CARE_NOCP },
            '{ {1'b0,1'b0,1'b0,4'h7,1'b1}, CARE_NOCP },
            '{ {1'b0,1'b1,1'b1,4'h7,1'b1}, CARE_ALL },
            '{ {1'b0,1'b1,1'b1,4'h7,1'b1}, CARE_ALL },
            '{ {1'b0,1'b1,1'b1,4'h5,1'b1}, CARE_ALL } };
    for (int i = 0; i < 5; i++) begin
      sb.push_back(ex[i]);
      drive(st[i]);
      e   = sb.pop_front();
      got = {stall, issue, condPass, nzcv, err};
      checks++;
      if ((got & e.care) !== (e.exp & e.care)) begin
        failures++;
        $display("FAIL err[%0d] got=%b expected=%b care=%b", i, got, e.exp, e.care);
      end else
        $display("err[%0d] ok out=%b", i, got);
    end
    // Asynchronous reset between clock edges must clear err and nzcv at once.
    sb.push_back('{ {1'b0,1'b0,1'b0,4'h0,1'b0}, CARE_NOCP });
    @(negedge clk);
    {idValid, idCond, idSetFlags, flush, exeFlagsValid, exeNzcv} = 12'h000;
    #2;
    rst = 1'b0;
    #1;
    e   = sb.pop_front();
    got = {stall, issue, condPass, nzcv, err};
    checks++;
    if ((got & e.care) !== (e.exp & e.care)) begin
      failures++;
      $display("FAIL err_async_reset got=%b expected=%b care=%b", got, e.exp, e.care);
    end else
      $display("err_async_reset ok out=%b", got);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_cond_sweep();
    exp_t       e;
    logic [7:0] got;
    for (int f = 0; f < 16; f++) begin
      // Load nzcv legitimately: one S instruction, then its writeback.
      sb.push_back('{ {1'b0,1'b1,1'b1,4'(f == 0 ? 0 : f - 1),1'b0}, CARE_NOCP });
      drive({1'b1, 4'hE, 1'b1, 1'b0, 1'b0, 4'h0});
      e   = sb.pop_front();
      got = {stall, issue, condPass, nzcv, err};
      checks++;
      if ((got & e.care) !== (e.exp & e.care)) begin
        failures++;
        $display("FAIL sweep_load[%0d] got=%b expected=%b", f, got, e.exp);
      end
      drive({1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'(f)});
      for (int c = 0; c < 16; c++) begin
        sb.push_back('{ {1'b0,1'b1,cond_ref(4'(c), 4'(f)),4'(f),1'b0}, CARE_ALL });
        drive({1'b1, 4'(c), 1'b0, 1'b0, 1'b0, 4'h0});
        e   = sb.pop_front();
        got = {stall, issue, condPass, nzcv, err};
        checks++;
        if ((got & e.care) !== (e.exp & e.care)) begin
          failures++;
          $display("FAIL sweep cond=%b nzcv=%b got=%b expected=%b", 4'(c), 4'(f), got, e.exp);
        end else
          $display("sweep cond=%b nzcv=%b ok pass=%b", 4'(c), 4'(f), condPass);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    {idValid, idCond, idSetFlags, flush, exeFlagsValid, exeNzcv} = 12'h000;
    test_reset();
    test_bypass();
    test_back_to_back();
    test_flush();
    test_err();
    test_cond_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
